// File: rtl/sprite_draw_engine.sv
// Rectangle walker feeding the VGA adapter write port: one pixel per clock per draw command.
// Optional SHIP_SPRITE_EN replaces the solid ship blocks with triangle masks.
module sprite_draw_engine #(
    parameter int         SCREEN_W      = 160,
    parameter int         SCREEN_H      = 120,
    parameter int         USER_Y        = 110,
    parameter int         ENEMY_Y       = 2,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter logic [2:0] SHIP_COLOUR   = 3'b010,
    parameter logic [2:0] ENEMY_COLOUR  = 3'b100,
    parameter logic [2:0] BULLET_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] user_x,
    input  logic [7:0] enemy_x,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t     state;
    logic [1:0] cmd_q;
    logic [7:0] ox_q;
    logic [6:0] oy_q;
    logic [7:0] col;
    logic [6:0] row;

    logic [7:0] in_ox, w_m1, nx_col, s_col, s_ox;
    logic [6:0] in_oy, h_m1, nx_row, s_row, s_oy;
    logic [1:0] s_cmd;
    logic [8:0] sx;
    logic [7:0] sy;
    logic [2:0] s_colour;
    logic       last, vis, mask_on;

    // Origin selection from the live inputs, used only when a command is accepted
    always_comb begin
        in_ox = 8'd0;
        in_oy = 7'd0;
        case (cmd)
            2'd1: begin in_ox = user_x;   in_oy = 7'(USER_Y);  end
            2'd2: begin in_ox = enemy_x;  in_oy = 7'(ENEMY_Y); end
            2'd3: begin in_ox = bullet_x; in_oy = bullet_y;    end
            default: ;
        endcase
    end

    always_comb begin
        w_m1 = 8'd7;
        h_m1 = 7'd7;
        case (cmd_q)
            2'd0: begin w_m1 = 8'(SCREEN_W - 1); h_m1 = 7'(SCREEN_H - 1); end
            2'd3: begin w_m1 = 8'd0;             h_m1 = 7'd3;             end
            default: ;
        endcase
        last   = (col == w_m1) && (row == h_m1);
        nx_col = (col == w_m1) ? 8'd0 : col + 8'd1;
        nx_row = (col == w_m1) ? row + 7'd1 : row;
    end

    // The pixel registered this edge: (0,0) of the new command in IDLE, else the next one
    always_comb begin
        if (state == IDLE) begin
            s_cmd = cmd;   s_ox = in_ox; s_oy = in_oy; s_col = 8'd0;   s_row = 7'd0;
        end else begin
            s_cmd = cmd_q; s_ox = ox_q;  s_oy = oy_q;  s_col = nx_col; s_row = nx_row;
        end
        sx  = {1'b0, s_ox} + {1'b0, s_col};
        sy  = {1'b0, s_oy} + {1'b0, s_row};
        vis = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
        case (s_cmd)
            2'd0:    s_colour = BG_COLOUR;
            2'd1:    s_colour = SHIP_COLOUR;
            2'd2:    s_colour = ENEMY_COLOUR;
            default: s_colour = BULLET_COLOUR;
        endcase
    end

`ifdef SHIP_SPRITE_EN
    logic [2:0] m_r, m_h;
    always_comb begin
        // Enemy flips the row index so its triangle points down
        m_r     = (s_cmd == 2'd2) ? 3'd7 - s_row[2:0] : s_row[2:0];
        m_h     = (3'd7 - m_r) >> 1;
        mask_on = 1'b1;
        if (s_cmd == 2'd1 || s_cmd == 2'd2)
            mask_on = (s_col[2:0] >= m_h) && (s_col[2:0] <= 3'd7 - m_h);
    end
`else
    assign mask_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cmd_q  <= 2'd0;
            ox_q   <= 8'd0;
            oy_q   <= 7'd0;
            col    <= 8'd0;
            row    <= 7'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    plot <= 1'b0;
                    if (start) begin
                        state  <= DRAW;
                        busy   <= 1'b1;
                        cmd_q  <= cmd;
                        ox_q   <= in_ox;
                        oy_q   <= in_oy;
                        col    <= 8'd0;
                        row    <= 7'd0;
                        x      <= sx[7:0];
                        y      <= sy[6:0];
                        colour <= s_colour;
                        plot   <= vis && mask_on;
                    end
                end
                DRAW: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        plot  <= 1'b0;
                    end else begin
                        col    <= nx_col;
                        row    <= nx_row;
                        x      <= sx[7:0];
                        y      <= sy[6:0];
                        colour <= s_colour;
                        plot   <= vis && mask_on;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: pixel scoreboard plus handshake timing checks.
module tb_sprite_draw_engine;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] cmd;
    logic [7:0] user_x, enemy_x, bullet_x;
    logic [6:0] bullet_y;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    sprite_draw_engine dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .user_x(user_x), .enemy_x(enemy_x), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_busy = 0, n_plot = 0, n_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every plot must match the head of the expected-pixel queue
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) n_busy++;
            if (done) n_done++;
            if (plot) begin
                n_plot++;
                if (q.size() == 0) chk("extra_plot", 32'd1, 32'd0);
                else chk("pixel", {14'd0, x, y, colour}, {14'd0, q.pop_front()});
            end
        end
    end

    // Reference model: enumerate the rectangle, drop clipped and masked-out pixels
    function automatic int model(input int c, input int ux, input int ex, input int bx, input int by);
        int ox, oy, w, h, cnt, rr, hh;
        logic [2:0] cl;
        pix_t p;
        cnt = 0;
        case (c)
            0: begin ox = 0;  oy = 0;   w = 160; h = 120; cl = 3'b000; end
            1: begin ox = ux; oy = 110; w = 8;   h = 8;   cl = 3'b010; end
            2: begin ox = ex; oy = 2;   w = 8;   h = 8;   cl = 3'b100; end
            default: begin ox = bx; oy = by; w = 1; h = 4; cl = 3'b111; end
        endcase
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                if (ox + k < 160 && oy + r < 120) begin
`ifdef SHIP_SPRITE_EN
                    rr = (c == 2) ? 7 - r : r;
                    hh = (7 - rr) / 2;
                    if ((c == 1 || c == 2) && (k < hh || k > 7 - hh)) continue;
`else
                    rr = 0; hh = 0;
`endif
                    p.px = 8'(ox + k); p.py = 7'(oy + r); p.pc = cl;
                    q.push_back(p);
                    cnt++;
                end
            end
        end
        return cnt;
    endfunction

    // Issue a command and check latency, busy length, plot count and the single done pulse
    task automatic run_cmd(input string tag, input int c, input int ux, input int ex,
                           input int bx, input int by, input int n, input bit repulse);
        int exp_plots, b0, p0, d0, k;
        exp_plots = model(c, ux, ex, bx, by);
        b0 = n_busy; p0 = n_plot; d0 = n_done;
        @(negedge clk);
        cmd = 2'(c); user_x = 8'(ux); enemy_x = 8'(ex); bullet_x = 8'(bx); bullet_y = 7'(by);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scrambled inputs during DRAW must have no effect
        cmd = 2'(~c); user_x = 8'd3; enemy_x = 8'd3; bullet_x = 8'd3; bullet_y = 7'd3;
        chk({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
        k = 1;
        while (!done && k < n + 10) begin
            @(negedge clk);
            k++;
            if (repulse) start = (k == 2);
        end
        start = 1'b0;
        chk({tag, "_latency"}, k, n + 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_busy_cycles"}, n_busy - b0, n);
        chk({tag, "_plots"}, n_plot - p0, exp_plots);
        chk({tag, "_done_pulses"}, n_done - d0, 1);
        chk({tag, "_queue_empty"}, q.size(), 0);
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; cmd = 2'd0;
        user_x = 8'd0; enemy_x = 8'd0; bullet_x = 8'd0; bullet_y = 7'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", {14'd0, busy, done, plot, x, y, colour}, 32'd0);
        end

        run_cmd("bg",     0, 0,  0,   0,  0,   19200, 1'b0);
        run_cmd("ship",   1, 80, 0,   0,  0,   64,    1'b0);
        run_cmd("enemy",  2, 0,  156, 0,  0,   64,    1'b0);
        run_cmd("bullet", 3, 0,  0,   10, 118, 4,     1'b1);

        // Abandon a background fill mid-frame
        void'(model(0, 0, 0, 0, 0));
        @(negedge clk);
        cmd = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        chk("pre_reset_plot", {31'd0, plot}, 32'd1);
        d0 = n_done;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk("mid_reset_outs", {29'd0, plot, busy, done}, 32'd0);
        repeat (50) @(negedge clk);
        chk("mid_reset_no_done", n_done - d0, 0);
        chk("mid_reset_idle", {31'd0, busy}, 32'd0);

        run_cmd("ship2", 1, 20, 0, 0, 0, 64, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
